// File: rtl/product_out_buffer.sv
`default_nettype none
// ============================================================================
// Module      : product_out_buffer
// Description : Output FIFO for the multiplier's final-adder product. Adds
//               sequence tags and a saturating drop counter. Optional macro
//               PRODUCT_PARITY_EN adds stored parity and a parity-error pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module product_out_buffer #(
    parameter int PROD_W = 22,
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 4,
    parameter int OVF_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [PROD_W-1:0]          in_sum,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PROD_W-1:0]          out_prod,
    output logic [TAG_W-1:0]           out_tag,
    output logic [$clog2(DEPTH):0]     level,
    output logic [OVF_W-1:0]           drop_cnt,
`ifdef PRODUCT_PARITY_EN
    output logic                       out_par,
    output logic                       par_err,
`endif
    input  logic                       clr_drop
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;
    localparam logic [c_LVL_W-1:0] c_FULL    = c_LVL_W'(DEPTH);
    localparam logic [OVF_W-1:0]   c_OVF_MAX = {OVF_W{1'b1}};

    logic [PROD_W-1:0]  r_mem_prod [DEPTH];
    logic [TAG_W-1:0]   r_mem_tag  [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [TAG_W-1:0]   r_tag_cnt;
    logic [c_LVL_W-1:0] r_level;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [OVF_W-1:0]   r_drop_cnt;

    logic               w_push;
    logic               w_pop;
    logic               w_drop;
    logic [c_LVL_W-1:0] w_level_nxt;

    assign w_push      = in_valid && r_in_ready;
    assign w_pop       = r_out_valid && out_ready;
    assign w_drop      = in_valid && !r_in_ready;
    assign w_level_nxt = r_level + c_LVL_W'(w_push) - c_LVL_W'(w_pop);

    // Storage is cleared on reset so the head outputs read as zero when empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_prod[i] <= '0;
                r_mem_tag[i]  <= '0;
            end
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_tag_cnt   <= '0;
            r_level     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem_prod[r_wr_ptr] <= in_sum;
                r_mem_tag[r_wr_ptr]  <= r_tag_cnt;
                r_wr_ptr             <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            // Dropped products still consume a tag so the consumer sees the gap.
            if (in_valid) begin
                r_tag_cnt <= r_tag_cnt + 1'b1;
            end
            r_level     <= w_level_nxt;
            r_in_ready  <= (w_level_nxt != c_FULL);
            r_out_valid <= (w_level_nxt != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (clr_drop) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != c_OVF_MAX)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

`ifdef PRODUCT_PARITY_EN
    logic r_mem_par [DEPTH];
    logic r_par_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_par[i] <= 1'b0;
            end
            r_par_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem_par[r_wr_ptr] <= ^in_sum;
            end
            r_par_err <= w_pop && ((^r_mem_prod[r_rd_ptr]) != r_mem_par[r_rd_ptr]);
        end
    end

    assign out_par = r_mem_par[r_rd_ptr];
    assign par_err = r_par_err;
`endif

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_prod  = r_mem_prod[r_rd_ptr];
    assign out_tag   = r_mem_tag[r_rd_ptr];
    assign level     = r_level;
    assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_product_out_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_product_out_buffer
// Description : Directed self-checking bench for product_out_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_product_out_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, out_ready, clr_drop;
    logic [21:0] in_sum;
    logic        in_ready, out_valid;
    logic [21:0] out_prod;
    logic [3:0]  out_tag;
    logic [2:0]  level;
    logic [7:0]  drop_cnt;

    logic        in_valid2, out_ready2, clr_drop2;
    logic [21:0] in_sum2;
    logic        in_ready2, out_valid2;
    logic [21:0] out_prod2;
    logic [3:0]  out_tag2;
    logic [2:0]  level2;
    logic [1:0]  drop_cnt2;

`ifdef PRODUCT_PARITY_EN
    logic out_par, par_err, out_par2, par_err2;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    product_out_buffer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sum(in_sum),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_prod(out_prod), .out_tag(out_tag), .level(level),
        .drop_cnt(drop_cnt),
`ifdef PRODUCT_PARITY_EN
        .out_par(out_par), .par_err(par_err),
`endif
        .clr_drop(clr_drop)
    );

    product_out_buffer #(.OVF_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_sum(in_sum2),
        .in_ready(in_ready2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_prod(out_prod2), .out_tag(out_tag2), .level(level2),
        .drop_cnt(drop_cnt2),
`ifdef PRODUCT_PARITY_EN
        .out_par(out_par2), .par_err(par_err2),
`endif
        .clr_drop(clr_drop2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_drop = 1'b0; in_sum = '0;
        in_valid2 = 1'b0; out_ready2 = 1'b0; clr_drop2 = 1'b0; in_sum2 = '0;
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_prod",  32'(out_prod),  32'd0);
        check("rst_out_tag",   32'(out_tag),   32'd0);
        check("rst_level",     32'(level),     32'd0);
        check("rst_drop_cnt",  32'(drop_cnt),  32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        rst_n = 1'b1;

        // Single push then pop
        in_valid = 1'b1; in_sum = 22'h2A5F3;
        tick();
        in_valid = 1'b0;
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_prod",  32'(out_prod),  32'h2A5F3);
        check("single_tag",   32'(out_tag),   32'd0);
        check("single_level", 32'(level),     32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("pop_level", 32'(level),     32'd0);
        check("pop_valid", 32'(out_valid), 32'd0);

        // Fill to full, then three drops
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_sum = 22'(i);
            tick();
        end
        check("full_level",    32'(level),    32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            in_sum = 22'h3DEAD0 + 22'(i);
            tick();
        end
        in_valid = 1'b0;
        check("drop_cnt_3",  32'(drop_cnt), 32'd3);
        check("drop_level",  32'(level),    32'd4);
        check("drop_head",   32'(out_prod), 32'd1);
        check("drop_tag",    32'(out_tag),  32'd0);

        // Drain in order
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check("drain_prod", 32'(out_prod), 32'(k));
            check("drain_tag",  32'(out_tag),  32'(k - 1));
            tick();
        end
        out_ready = 1'b0;
        check("drain_level", 32'(level),     32'd0);
        check("drain_valid", 32'(out_valid), 32'd0);

        // Next accepted push carries tag 7 (tags 4..6 went to drops)
        in_valid = 1'b1; in_sum = 22'd5;
        tick();
        check("gap_tag",  32'(out_tag),  32'd7);
        check("gap_prod", 32'(out_prod), 32'd5);
        in_sum = 22'd6;
        tick();
        check("two_level", 32'(level), 32'd2);

        // Streaming push+pop at level 2; tag wraps 15 -> 0
        out_ready = 1'b1;
        for (int j = 0; j < 10; j++) begin
            in_sum = 22'(7 + j);
            check("stream_prod", 32'(out_prod), 32'(5 + j));
            check("stream_tag",  32'(out_tag),  32'((7 + j) % 16));
            tick();
            check("stream_level", 32'(level), 32'd2);
        end
        in_valid = 1'b0;
        check("tail_prod0", 32'(out_prod), 32'd15);
        check("tail_tag0",  32'(out_tag),  32'd1);
        tick();
        check("tail_prod1", 32'(out_prod), 32'd16);
        check("tail_tag1",  32'(out_tag),  32'd2);
        tick();
        out_ready = 1'b0;
        check("tail_level", 32'(level), 32'd0);

        // Clear of the default-width counter
        clr_drop = 1'b1;
        tick();
        clr_drop = 1'b0;
        check("clr_drop", 32'(drop_cnt), 32'd0);

        // Saturation with a 2-bit counter
        in_valid2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_sum2 = 22'(i);
            tick();
        end
        check("sat_full", 32'(in_ready2), 32'd0);
        for (int i = 0; i < 2; i++) tick();
        check("sat_cnt2", 32'(drop_cnt2), 32'd2);
        for (int i = 0; i < 3; i++) tick();
        check("sat_cnt3", 32'(drop_cnt2), 32'd3);
        clr_drop2 = 1'b1;
        tick();
        clr_drop2 = 1'b0;
        check("clr_wins", 32'(drop_cnt2), 32'd0);
        tick();
        in_valid2 = 1'b0;
        check("post_clr_cnt", 32'(drop_cnt2), 32'd1);

        // Reset mid-operation with three entries held
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_sum = 22'h100 + 22'(i);
            tick();
        end
        in_valid = 1'b0;
        check("pre_rst_level", 32'(level), 32'd3);
        rst_n = 1'b0;
        tick();
        check("mid_rst_level",    32'(level),     32'd0);
        check("mid_rst_valid",    32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready),  32'd1);
        check("mid_rst_tag",      32'(out_tag),   32'd0);
        check("mid_rst_prod",     32'(out_prod),  32'd0);
        rst_n = 1'b1;
        in_valid = 1'b1; in_sum = 22'h3FFFFF;
        tick();
        in_valid = 1'b0;
        check("post_rst_tag",   32'(out_tag),  32'd0);
        check("post_rst_prod",  32'(out_prod), 32'h3FFFFF);
        check("post_rst_level", 32'(level),    32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
